// File: rtl/board_pkg.sv
// Shared board-game definitions: coordinate type, default board geometry and
// the movement state encoding used by the player controller and renderers.
package board_pkg;

  typedef logic [9:0] coord_t;

  localparam int X0           = 16;
  localparam int GROUND_Y     = 124;
  localparam int TILE_W       = 32;
  localparam int NUM_TILES    = 16;
  localparam int HOP_FRAMES   = 16;
  localparam int HOP_H        = 16;
  localparam int PAUSE_FRAMES = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HOP_UP,
    HOP_DOWN,
    PAUSE,
    DONE
  } move_state_t;

endpackage

// File: rtl/frame_phase_counter.sv
// Tick-gated phase counter: counts frame ticks up to a terminal count, flags the
// terminal tick and wraps to zero so back-to-back phases need no explicit reload.
module frame_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         last
);

  logic [W-1:0] count;

  assign last = tick & (count == term - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: accepts a dice move and animates the sprite hopping
// tile to tile, updating position only on frame ticks, then pulses move_done.
module player_move_ctrl #(
  parameter int X0           = board_pkg::X0,
  parameter int GROUND_Y     = board_pkg::GROUND_Y,
  parameter int TILE_W       = board_pkg::TILE_W,
  parameter int NUM_TILES    = board_pkg::NUM_TILES,
  parameter int HOP_FRAMES   = board_pkg::HOP_FRAMES,
  parameter int HOP_H        = board_pkg::HOP_H,
  parameter int PAUSE_FRAMES = board_pkg::PAUSE_FRAMES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         move_valid,
  input  logic [2:0]                   move_steps,
  output logic                         move_ready,
  output board_pkg::coord_t            player_x,
  output board_pkg::coord_t            player_y,
  output logic [$clog2(NUM_TILES)-1:0] tile_index,
  output logic                         move_done
);

  import board_pkg::*;

  localparam int     TW   = $clog2(NUM_TILES);
  localparam int     HALF = HOP_FRAMES / 2;
  localparam coord_t DX   = coord_t'(TILE_W / HOP_FRAMES);
  localparam coord_t DY   = coord_t'(HOP_H / HALF);
  localparam coord_t X0_C = coord_t'(X0);
  localparam coord_t GY_C = coord_t'(GROUND_Y);

  if (GROUND_Y < HOP_H) begin : g_apex_chk
    $error("hop apex would go above y=0");
  end
  if ((HOP_FRAMES % 2) != 0 || (TILE_W % HOP_FRAMES) != 0 || (HOP_H % HALF) != 0) begin : g_geom_chk
    $error("hop geometry does not divide evenly");
  end

  move_state_t   state;
  logic [2:0]    steps_left;
  logic          wrap_hop;
  logic [TW-1:0] next_tile;
  coord_t        land_x;
  logic          counting;
  logic [7:0]    cnt_term;
  logic          cnt_last;

  assign wrap_hop  = (tile_index == TW'(NUM_TILES - 1));
  assign next_tile = wrap_hop ? '0 : tile_index + TW'(1);
  assign land_x    = X0_C + coord_t'(next_tile) * coord_t'(TILE_W);
  assign counting  = (state == HOP_UP) || (state == HOP_DOWN) || (state == PAUSE);
  assign cnt_term  = (state == PAUSE) ? 8'(PAUSE_FRAMES) : 8'(HALF);

  frame_phase_counter #(.W(8)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (~counting),
    .tick  (frame_tick & counting),
    .term  (cnt_term),
    .last  (cnt_last)
  );

  // The wrap hop keeps x still for its whole arc; landing snaps x to the tile grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      steps_left <= '0;
      tile_index <= '0;
      player_x   <= X0_C;
      player_y   <= GY_C;
      move_ready <= 1'b1;
      move_done  <= 1'b0;
    end else begin
      move_done <= 1'b0;
      case (state)
        IDLE: begin
          if (move_valid && move_ready) begin
            steps_left <= move_steps;
            move_ready <= 1'b0;
            if (move_steps == 3'd0) begin
              state     <= DONE;
              move_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (frame_tick) state <= HOP_UP;
        end
        HOP_UP: begin
          if (frame_tick) begin
            if (!wrap_hop) player_x <= player_x + DX;
            player_y <= player_y - DY;
            if (cnt_last) state <= HOP_DOWN;
          end
        end
        HOP_DOWN: begin
          if (frame_tick) begin
            if (cnt_last) begin
              tile_index <= next_tile;
              player_x   <= land_x;
              player_y   <= GY_C;
              steps_left <= steps_left - 3'd1;
              if (steps_left == 3'd1) begin
                state     <= DONE;
                move_done <= 1'b1;
              end else if (PAUSE_FRAMES == 0) begin
                state <= HOP_UP;
              end else begin
                state <= PAUSE;
              end
            end else begin
              if (!wrap_hop) player_x <= player_x + DX;
              player_y <= player_y + DY;
            end
          end
        end
        PAUSE: begin
          if (cnt_last) state <= HOP_UP;
        end
        DONE: begin
          state      <= IDLE;
          move_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
